mf_capture_buffer: RTL and testbench

- Capture and readout block at the output end of the matched-filter stream. It accepts NSAMP signed samples per aclk, the same packing the matched filter emits, and stores them in a circular buffer with pre-trigger history.
- A trigger is either a threshold crossing or an external pulse. On a trigger it freezes a window of DEPTH words and then streams the window out one sample at a time over a valid/ready interface.
- Used for offline filter characterisation and for impulse-response capture.

---
 rtl/mf_capture_buffer_if.sv | 20 ++
 rtl/mf_capture_buffer.sv | 166 ++++++++++++++++
 tb/tb_mf_capture_buffer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mf_capture_buffer_if.sv
// ============================================================================
//  Module   : mf_capture_buffer_if
//  Brief    : Readout stream of the matched-filter capture buffer (valid/ready).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface mf_capture_buffer_if #(
  parameter int NBITS = 12
);
  logic [NBITS-1:0] rd_data_o;
  logic             rd_valid_o;
  logic             rd_ready_i;
  logic             rd_last_o;

  modport master (output rd_data_o, output rd_valid_o, output rd_last_o, input rd_ready_i);
  modport slave  (input rd_data_o, input rd_valid_o, input rd_last_o, output rd_ready_i);
endinterface

`default_nettype wire

// File: rtl/mf_capture_buffer.sv
// ============================================================================
//  Module   : mf_capture_buffer
//  Brief    : Circular capture of the filter output with pre-trigger history
//             and sample-by-sample readout of the frozen window.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mf_capture_buffer #(
  parameter int NSAMP   = 4,
  parameter int NBITS   = 12,
  parameter int DEPTH   = 256,
  parameter int PRETRIG = 64
) (
  input  wire logic                       aclk,
  input  wire logic                       aresetn,
  input  wire logic [NSAMP*NBITS-1:0]     data_i,
  input  wire logic                       arm_i,
  input  wire logic                       trig_i,
  input  wire logic [NBITS-2:0]           thresh_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic [$clog2(DEPTH)-1:0]        trig_addr_o,
  mf_capture_buffer_if.master             rd
);

  localparam int c_W  = NSAMP * NBITS;
  localparam int c_AW = $clog2(DEPTH);
  localparam int c_SW = (NSAMP > 1) ? $clog2(NSAMP) : 1;
  localparam int c_POST_LEN = DEPTH - PRETRIG - 1;

  localparam logic [NBITS-1:0] c_ONE_S    = NBITS'(1);
  localparam logic [c_AW-1:0]  c_ONE_A    = c_AW'(1);
  localparam logic [c_AW-1:0]  c_PRE      = c_AW'(PRETRIG);
  localparam logic [c_AW-1:0]  c_FILL_END = c_AW'(PRETRIG - 1);
  localparam logic [c_AW-1:0]  c_POST_END = c_AW'(DEPTH - PRETRIG - 2);
  localparam logic [c_AW:0]    c_DEPTH_W  = (c_AW+1)'(DEPTH);
  localparam logic [c_AW:0]    c_ONE_L    = (c_AW+1)'(1);
  localparam logic [c_SW-1:0]  c_SLAST    = c_SW'(NSAMP - 1);
  localparam logic [c_SW-1:0]  c_ONE_SW   = c_SW'(1);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_FILL  = 3'd1;
  localparam logic [2:0] c_ARMED = 3'd2;
  localparam logic [2:0] c_POST  = 3'd3;
  localparam logic [2:0] c_READ  = 3'd4;

  logic [2:0]       r_state, w_next;
  logic [c_W-1:0]   r_data;
  logic             r_trig;
  logic [c_AW-1:0]  r_wptr, r_cnt, r_raddr, r_trig_addr;
  logic [c_W-1:0]   r_mem [DEPTH];
  logic [c_W-1:0]   r_ramq, r_word;
  logic             r_qvalid, r_wvalid;
  logic [c_SW-1:0]  r_sidx;
  logic [c_AW:0]    r_wleft;
  logic [NSAMP-1:0] w_hit_vec;
  logic [NBITS-1:0] w_samp [NSAMP];
  logic             w_trig_evt, w_we, w_hs, w_sidx_end, w_last, w_load;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_data <= '0;
      r_trig <= 1'b0;
    end else begin
      r_data <= data_i;
      r_trig <= trig_i;
    end
  end

  // Magnitude of the most negative code saturates so it fits the threshold width.
  for (genvar k = 0; k < NSAMP; k++) begin : g_samp
    logic [NBITS-1:0] w_s, w_neg;
    logic [NBITS-2:0] w_mag;
    assign w_s   = r_data[NBITS*k +: NBITS];
    assign w_neg = ~w_s + c_ONE_S;
    assign w_mag = !w_s[NBITS-1] ? w_s[NBITS-2:0] :
                   (w_neg[NBITS-1] ? {(NBITS-1){1'b1}} : w_neg[NBITS-2:0]);
    assign w_hit_vec[k] = (w_mag >= thresh_i);
    assign w_samp[k]    = r_word[NBITS*k +: NBITS];
  end

  assign w_trig_evt = (|w_hit_vec) | r_trig;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= c_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:  if (arm_i) w_next = c_FILL;
      c_FILL:  if (r_cnt == c_FILL_END) w_next = c_ARMED;
      c_ARMED: if (w_trig_evt) w_next = (c_POST_LEN == 0) ? c_READ : c_POST;
      c_POST:  if (r_cnt == c_POST_END) w_next = c_READ;
      c_READ:  if (w_hs && w_last) w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  always_comb begin
    w_we   = (r_state == c_FILL) || (r_state == c_ARMED) || (r_state == c_POST);
    busy_o = (r_state != c_IDLE);
    done_o = (r_state == c_READ);
  end

  always_ff @(posedge aclk) begin
    if (w_we) r_mem[r_wptr] <= r_data;
    r_ramq <= r_mem[r_raddr];
  end

  assign w_hs       = r_wvalid && rd.rd_ready_i;
  assign w_sidx_end = (r_sidx == c_SLAST);
  assign w_last     = r_wvalid && w_sidx_end && (r_wleft == '0);
  // r_qvalid means r_ramq already reflects the current r_raddr.
  assign w_load     = (r_state == c_READ) && r_qvalid && (r_wleft != '0) &&
                      (!r_wvalid || (w_hs && w_sidx_end));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wptr      <= '0;
      r_cnt       <= '0;
      r_trig_addr <= '0;
      r_raddr     <= '0;
      r_wleft     <= '0;
      r_qvalid    <= 1'b0;
      r_wvalid    <= 1'b0;
      r_sidx      <= '0;
      r_word      <= '0;
    end else begin
      if (w_we) r_wptr <= r_wptr + c_ONE_A;
      if (((r_state == c_FILL) || (r_state == c_POST)) && (w_next == r_state))
        r_cnt <= r_cnt + c_ONE_A;
      else
        r_cnt <= '0;
      if ((r_state == c_ARMED) && w_trig_evt) begin
        r_trig_addr <= r_wptr;
        r_raddr     <= r_wptr - c_PRE;
      end else if (w_load) begin
        r_raddr <= r_raddr + c_ONE_A;
      end
      if ((w_next == c_READ) && (r_state != c_READ))
        r_wleft <= c_DEPTH_W;
      else if (w_load)
        r_wleft <= r_wleft - c_ONE_L;
      r_qvalid <= (r_state == c_READ) && (w_next == c_READ) && !w_load;
      if (w_load) begin
        r_word   <= r_ramq;
        r_wvalid <= 1'b1;
        r_sidx   <= '0;
      end else if (w_hs) begin
        if (w_sidx_end) r_wvalid <= 1'b0;
        else            r_sidx   <= r_sidx + c_ONE_SW;
      end
    end
  end

  assign trig_addr_o   = r_trig_addr;
  assign rd.rd_data_o  = w_samp[r_sidx];
  assign rd.rd_valid_o = r_wvalid;
  assign rd.rd_last_o  = w_last;

endmodule

`default_nettype wire

// File: tb/tb_mf_capture_buffer.sv
// ============================================================================
//  Module   : tb_mf_capture_buffer
//  Brief    : Directed capture/readout scenarios with a sample scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mf_capture_buffer;
  localparam int NSAMP = 4;
  localparam int NBITS = 12;
  localparam int DEPTH = 256;
  localparam int PRE   = 64;
  localparam int POSTW = DEPTH - PRE;   // words written from the trigger word on

  logic                   aclk = 1'b0;
  logic                   aresetn = 1'b0;
  logic [NSAMP*NBITS-1:0] data_i = '0;
  logic                   arm_i = 1'b0;
  logic                   trig_i = 1'b0;
  logic [NBITS-2:0]       thresh_i = '0;
  logic                   busy_o, done_o;
  logic [7:0]             trig_addr_o;

  mf_capture_buffer_if #(.NBITS(NBITS)) rd_if ();

  mf_capture_buffer #(.NSAMP(NSAMP), .NBITS(NBITS), .DEPTH(DEPTH), .PRETRIG(PRE)) dut (
    .aclk(aclk), .aresetn(aresetn), .data_i(data_i), .arm_i(arm_i), .trig_i(trig_i),
    .thresh_i(thresh_i), .busy_o(busy_o), .done_o(done_o), .trig_addr_o(trig_addr_o),
    .rd(rd_if.master)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;
  int ptr0   = 0;
  logic [NBITS-1:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: single impulse word at T; mode 1: ramp; mode 2: ramp with -2048 in sample 2 at T
  function automatic logic [NSAMP*NBITS-1:0] gen(input int mode, input int n, input int T,
                                                 input logic [NSAMP*NBITS-1:0] imp);
    logic [NSAMP*NBITS-1:0] w;
    w = '0;
    if (mode == 0) begin
      if (n == T) w = imp;
    end else begin
      for (int k = 0; k < NSAMP; k++) w[NBITS*k +: NBITS] = NBITS'((4*n + k) % 1024);
      if (mode == 2 && n == T) w[NBITS*2 +: NBITS] = 12'h800;
    end
    return w;
  endfunction

  task automatic capture(input int mode, input int T, input logic [NSAMP*NBITS-1:0] imp,
                         input logic [NBITS-2:0] th, input int trig_n, input int rdy_pct,
                         input int stop_after);
    logic [NSAMP*NBITS-1:0] w;
    bit busy_ok, done_low, first, prev_stall;
    int cyc, lat, got;
    busy_ok = 1; done_low = 1; first = 0; prev_stall = 0; lat = 0; got = 0;
    thresh_i = th;
    @(negedge aclk);
    for (int n = 0; n <= T + POSTW - 1; n++) begin
      w      = gen(mode, n, T, imp);
      data_i = w;
      trig_i = (n == trig_n);
      arm_i  = (n == 0);
      if (n >= T - PRE)
        for (int k = 0; k < NSAMP; k++) exp_q.push_back(w[NBITS*k +: NBITS]);
      @(posedge aclk);
      @(negedge aclk);
      busy_ok  &= busy_o;
      done_low &= !done_o;
    end
    data_i = '0; trig_i = 1'b0; arm_i = 1'b0;
    check("busy_during_capture", busy_ok, 1);
    check("done_low_during_capture", done_low, 1);
    cyc = 0;
    while (!done_o && cyc < 10) begin
      @(negedge aclk);
      cyc++;
    end
    check("done_reached", done_o, 1);
    check("trig_addr", trig_addr_o, (ptr0 + T) % DEPTH);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20000 && got < stop_after) begin
      check("busy_in_read", busy_o, 1);
      if (prev_stall) check("valid_held_on_stall", rd_if.rd_valid_o, 1);
      if (!first) begin
        if (rd_if.rd_valid_o) begin
          check("first_valid_latency", lat <= 2, 1);
          first = 1;
        end else lat++;
      end
      if (rd_if.rd_valid_o) begin
        check("rd_data", rd_if.rd_data_o, exp_q[0]);
        check("rd_last", rd_if.rd_last_o, exp_q.size() == 1);
      end
      rd_if.rd_ready_i = ($urandom_range(99) < rdy_pct);
      prev_stall = rd_if.rd_valid_o && !rd_if.rd_ready_i;
      if (rd_if.rd_valid_o && rd_if.rd_ready_i) begin
        void'(exp_q.pop_front());
        got++;
      end
      @(negedge aclk);
      cyc++;
    end
    if (got < stop_after) begin
      check("all_samples_read", exp_q.size(), 0);
      check("idle_after_last", {busy_o, done_o, rd_if.rd_valid_o}, 3'b000);
    end
    rd_if.rd_ready_i = 1'b0;
    ptr0 = (ptr0 + T + POSTW) % DEPTH;
  endtask

  initial begin
    rd_if.rd_ready_i = 1'b0;
    #12;
    check("reset_outputs", {busy_o, done_o, trig_addr_o, rd_if.rd_valid_o, rd_if.rd_last_o,
                            rd_if.rd_data_o}, '0);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (3) @(negedge aclk);

    // 1: negative impulse in sample 1 at word 99
    capture(0, 99, 48'h000_000_C00_000, 11'd512, -1, 100, 1 << 30);
    // 2: positive impulse in sample 3
    capture(0, 70, 48'h400_000_000_000, 11'd512, -1, 100, 1 << 30);
    // 3: force trigger during FILL is ignored; threshold hit at word 150 wins
    capture(0, 150, 48'h000_000_000_258, 11'd512, 10, 100, 1 << 30);
    // 4: long ARMED wait wraps the write pointer, external trigger
    capture(1, 1064, '0, 11'd2047, 1064, 100, 1 << 30);
    // 5: same as 1 under 30% ready
    capture(0, 99, 48'h000_000_C00_000, 11'd512, -1, 30, 1 << 30);
    // 6a: reset after 300 samples of readout
    capture(0, 99, 48'h000_000_C00_000, 11'd512, -1, 100, 300);
    aresetn = 1'b0;
    #1;
    check("reset_mid_read", {busy_o, done_o, trig_addr_o, rd_if.rd_valid_o, rd_if.rd_last_o,
                             rd_if.rd_data_o}, '0);
    exp_q.delete();
    ptr0 = 0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    // 6b: zero threshold triggers on the first ARMED word
    capture(1, 64, '0, 11'd0, -1, 100, 1 << 30);
    // 6c: -2048 reaches the maximum threshold
    capture(2, 80, '0, 11'd2047, -1, 100, 1 << 30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
